// File: rtl/hunch_match_ctrl.sv
// Match sequencer for the three-player Hunch game.
// Runs the game FSM one round at a time by pulsing its reset, scores each round from the
// winner mask, voids rounds that run too long, and declares the match winner.
module hunch_match_ctrl #(
    parameter int WIN_SCORE     = 3,
    parameter int MAX_ROUNDS    = 7,
    parameter int ROUND_TIMEOUT = 1000,
    parameter int GAP_CYCLES    = 4,
    parameter int SW            = 4,
    parameter int RW            = 4,
    parameter int TW            = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    input  logic          ABORT,
    input  logic [2:0]    WINNER,
    input  logic          WINNER_VALID,
    output logic          GAME_RST,
    output logic          ROUND_ACTIVE,
    output logic          TIMEOUT,
    output logic [RW-1:0] ROUND_NUM,
    output logic [SW-1:0] SCORE_A,
    output logic [SW-1:0] SCORE_B,
    output logic [SW-1:0] SCORE_C,
    output logic          MATCH_DONE,
    output logic [2:0]    MATCH_WINNER,
    output logic [2:0]    DBG_STATE
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_PLAY  = 3'd2,
        S_SCORE = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [2:0]    mask;
    logic          timer_hit;
    logic          gap_last;
    logic          match_over;
    logic          start_match;
    logic [SW-1:0] top;
    logic [2:0]    top_mask;

    assign DBG_STATE = state;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] s, input logic inc);
        if (inc && (s != {SW{1'b1}})) return s + SW'(1);
        return s;
    endfunction

    // Next-state decode; ABORT overrides every other transition.
    always_comb begin
        state_nxt   = state;
        timer_hit   = (state == S_PLAY) && (timer == TW'(ROUND_TIMEOUT - 1));
        gap_last    = (state == S_GAP) && (timer == TW'(GAP_CYCLES - 1));
        match_over  = (SCORE_A >= SW'(WIN_SCORE)) || (SCORE_B >= SW'(WIN_SCORE)) ||
                      (SCORE_C >= SW'(WIN_SCORE)) || (ROUND_NUM == RW'(MAX_ROUNDS));
        start_match = !ABORT && START && ((state == S_IDLE) || (state == S_DONE));
        case (state)
            S_IDLE:  if (START) state_nxt = S_ARM;
            S_ARM:   state_nxt = S_PLAY;
            S_PLAY:  if (WINNER_VALID || timer_hit) state_nxt = S_SCORE;
            S_SCORE: state_nxt = S_GAP;
            S_GAP:   if (gap_last) state_nxt = match_over ? S_DONE : S_ARM;
            S_DONE:  if (START) state_nxt = S_ARM;
            default: state_nxt = S_IDLE;
        endcase
        if (ABORT) state_nxt = S_IDLE;
    end

    // Mask of every player sharing the top score; empty when nobody has scored.
    always_comb begin
        top = SCORE_A;
        if (SCORE_B > top) top = SCORE_B;
        if (SCORE_C > top) top = SCORE_C;
        top_mask = (top == '0) ? 3'b000 : {SCORE_A == top, SCORE_B == top, SCORE_C == top};
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Registered outputs, round timer, winner latch, scores and match result.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            GAME_RST     <= 1'b1;
            ROUND_ACTIVE <= 1'b0;
            TIMEOUT      <= 1'b0;
            MATCH_DONE   <= 1'b0;
            MATCH_WINNER <= 3'b000;
            ROUND_NUM    <= '0;
            SCORE_A      <= '0;
            SCORE_B      <= '0;
            SCORE_C      <= '0;
            timer        <= '0;
            mask         <= 3'b000;
        end else begin
            GAME_RST     <= (state_nxt != S_PLAY);
            ROUND_ACTIVE <= (state_nxt == S_PLAY);
            MATCH_DONE   <= (state_nxt == S_DONE);
            TIMEOUT      <= timer_hit && !WINNER_VALID && !ABORT;

            // The timer runs through PLAY (round timeout) and GAP (reset hold), zero elsewhere.
            if ((state == S_PLAY) || (state == S_GAP)) timer <= timer + TW'(1);
            else                                       timer <= '0;

            if (state == S_PLAY) begin
                if (WINNER_VALID)   mask <= WINNER;
                else if (timer_hit) mask <= 3'b000;
            end

            if (start_match) begin
                SCORE_A      <= '0;
                SCORE_B      <= '0;
                SCORE_C      <= '0;
                ROUND_NUM    <= '0;
                MATCH_WINNER <= 3'b000;
            end else if ((state == S_SCORE) && !ABORT) begin
                // A draw lights every bit but awards nobody.
                if (mask != 3'b111) begin
                    SCORE_A <= sat_inc(SCORE_A, mask[2]);
                    SCORE_B <= sat_inc(SCORE_B, mask[1]);
                    SCORE_C <= sat_inc(SCORE_C, mask[0]);
                end
                if (ROUND_NUM != {RW{1'b1}}) ROUND_NUM <= ROUND_NUM + RW'(1);
            end

            if ((state == S_GAP) && (state_nxt == S_DONE)) MATCH_WINNER <= top_mask;
        end
    end

endmodule

// File: tb/tb_hunch_match_ctrl.sv
// Bench for hunch_match_ctrl. Two instances share stimulus: the main one (round limit 7) and
// a short-match one (round limit 2); the observed outputs are selected by use2.
module tb_hunch_match_ctrl;

    localparam int W = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] winner = 3'b000;
    logic       winner_valid = 1'b0;
    logic       use2 = 1'b0;

    logic       d1_game_rst, d1_round_active, d1_timeout, d1_match_done;
    logic [3:0] d1_round_num, d1_score_a, d1_score_b, d1_score_c;
    logic [2:0] d1_match_winner, d1_state;
    logic       d2_game_rst, d2_round_active, d2_timeout, d2_match_done;
    logic [3:0] d2_round_num, d2_score_a, d2_score_b, d2_score_c;
    logic [2:0] d2_match_winner, d2_state;

    logic       o_game_rst, o_round_active, o_timeout, o_match_done;
    logic [3:0] o_round_num, o_score_a, o_score_b, o_score_c;
    logic [2:0] o_match_winner, o_state;

    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           to_cnt = 0;
    int           max_rounds = 7;
    logic [3:0]   m_a, m_b, m_c, m_round;

    hunch_match_ctrl #(.WIN_SCORE(3), .MAX_ROUNDS(7), .ROUND_TIMEOUT(10), .GAP_CYCLES(4),
                       .SW(4), .RW(4), .TW(16)) u_dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .ABORT(abort), .WINNER(winner),
        .WINNER_VALID(winner_valid), .GAME_RST(d1_game_rst), .ROUND_ACTIVE(d1_round_active),
        .TIMEOUT(d1_timeout), .ROUND_NUM(d1_round_num), .SCORE_A(d1_score_a),
        .SCORE_B(d1_score_b), .SCORE_C(d1_score_c), .MATCH_DONE(d1_match_done),
        .MATCH_WINNER(d1_match_winner), .DBG_STATE(d1_state));

    hunch_match_ctrl #(.WIN_SCORE(3), .MAX_ROUNDS(2), .ROUND_TIMEOUT(10), .GAP_CYCLES(4),
                       .SW(4), .RW(4), .TW(16)) u_dut2 (
        .CLK(clk), .RST_N(rst_n), .START(start), .ABORT(abort), .WINNER(winner),
        .WINNER_VALID(winner_valid), .GAME_RST(d2_game_rst), .ROUND_ACTIVE(d2_round_active),
        .TIMEOUT(d2_timeout), .ROUND_NUM(d2_round_num), .SCORE_A(d2_score_a),
        .SCORE_B(d2_score_b), .SCORE_C(d2_score_c), .MATCH_DONE(d2_match_done),
        .MATCH_WINNER(d2_match_winner), .DBG_STATE(d2_state));

    // Clock and observed-instance select.
    always #5 clk = ~clk;

    always_comb begin
        o_game_rst     = use2 ? d2_game_rst     : d1_game_rst;
        o_round_active = use2 ? d2_round_active : d1_round_active;
        o_timeout      = use2 ? d2_timeout      : d1_timeout;
        o_match_done   = use2 ? d2_match_done   : d1_match_done;
        o_round_num    = use2 ? d2_round_num    : d1_round_num;
        o_score_a      = use2 ? d2_score_a      : d1_score_a;
        o_score_b      = use2 ? d2_score_b      : d1_score_b;
        o_score_c      = use2 ? d2_score_c      : d1_score_c;
        o_match_winner = use2 ? d2_match_winner : d1_match_winner;
        o_state        = use2 ? d2_state        : d1_state;
    end

    always @(negedge clk) if (o_timeout) to_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model_winner();
        logic [3:0] top;
        top = m_a;
        if (m_b > top) top = m_b;
        if (m_c > top) top = m_c;
        if (top == 4'd0) return 3'b000;
        return {m_a == top, m_b == top, m_c == top};
    endfunction

    task automatic start_match();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        m_a = 0; m_b = 0; m_c = 0; m_round = 0;
        check("start_done_clr", o_match_done, 1'b0);
        check("start_score_clr", {o_score_a, o_score_b, o_score_c, o_round_num}, 16'h0);
        check("start_winner_clr", o_match_winner, 3'b000);
    endtask

    task automatic wait_active();
        int i = 0;
        while (!o_round_active && i < 100) begin @(negedge clk); i++; end
        check("play_entry", o_round_active, 1'b1);
    endtask

    // Push the model result for the round just driven, then compare once ROUND_NUM moves.
    task automatic score_round(input logic [2:0] m, input logic [3:0] prev);
        logic [W-1:0] e;
        int i = 0;
        if (m != 3'b111) begin
            if (m[2] && m_a != 4'hf) m_a++;
            if (m[1] && m_b != 4'hf) m_b++;
            if (m[0] && m_c != 4'hf) m_c++;
        end
        if (m_round != 4'hf) m_round++;
        exp_q.push_back({m_round, m_a, m_b, m_c});
        while (o_round_num == prev && i < 100) begin @(negedge clk); i++; end
        e = exp_q.pop_front();
        check("round_num", o_round_num, e[15:12]);
        check("score_a", o_score_a, e[11:8]);
        check("score_b", o_score_b, e[7:4]);
        check("score_c", o_score_c, e[3:0]);
        if (m_a >= 3 || m_b >= 3 || m_c >= 3 || int'(m_round) == max_rounds) begin
            i = 0;
            while (!o_match_done && i < 50) begin @(negedge clk); i++; end
            check("match_done", o_match_done, 1'b1);
            check("match_winner", o_match_winner, model_winner());
            check("done_game_rst", o_game_rst, 1'b1);
        end else begin
            check("not_done", o_match_done, 1'b0);
        end
    endtask

    task automatic play_round(input logic [2:0] m, input int delay);
        logic [3:0] prev;
        wait_active();
        prev = o_round_num;
        check("play_game_rst", o_game_rst, 1'b0);
        repeat (delay) @(negedge clk);
        winner = m; winner_valid = 1'b1;
        @(negedge clk);
        winner_valid = 1'b0; winner = 3'b000;
        score_round(m, prev);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int k;
        int to_before;
        logic [3:0] prev;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_game_rst", o_game_rst, 1'b1);
        check("rst_outputs", {o_round_active, o_timeout, o_match_done, o_match_winner}, 6'h0);
        check("rst_counters", {o_score_a, o_score_b, o_score_c, o_round_num}, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Straight win for A
        start_match();
        repeat (3) play_round(3'b100, $urandom_range(0, 5));

        // Shared points, a draw, then C takes it
        start_match();
        play_round(3'b110, $urandom_range(0, 5));
        play_round(3'b011, $urandom_range(0, 5));
        play_round(3'b101, $urandom_range(0, 5));
        play_round(3'b111, $urandom_range(0, 5));
        play_round(3'b001, $urandom_range(0, 5));

        // Timeout: pulse exactly 10 cycles after PLAY entry, one cycle wide
        start_match();
        wait_active();
        prev = o_round_num;
        to_before = to_cnt;
        k = 0;
        while (!o_timeout && k < 50) begin @(negedge clk); k++; end
        check("timeout_latency", k, 10);
        @(negedge clk);
        check("timeout_width", o_timeout, 1'b0);
        score_round(3'b000, prev);
        check("timeout_pulses", to_cnt - to_before, 1);
        play_round(3'b010, 2);

        // ABORT during PLAY
        wait_active();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_state", o_state, 3'd0);
        check("abort_game_rst", o_game_rst, 1'b1);
        check("abort_active", o_round_active, 1'b0);
        check("abort_held", {o_score_a, o_score_b, o_score_c, o_round_num}, {m_a, m_b, m_c, m_round});

        // Winner on the timeout cycle wins, no TIMEOUT
        start_match();
        to_before = to_cnt;
        play_round(3'b100, 9);
        check("race_no_timeout", to_cnt - to_before, 0);

        // Asynchronous reset while in GAP
        check("in_gap", o_state, 3'd4);
        #2 rst_n = 1'b0;
        #1;
        check("arst_game_rst", o_game_rst, 1'b1);
        check("arst_outputs", {o_round_active, o_timeout, o_match_done, o_match_winner}, 6'h0);
        check("arst_counters", {o_score_a, o_score_b, o_score_c, o_round_num}, 16'h0);
        check("arst_state", o_state, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Round limit of 2, then restart
        use2 = 1'b1;
        max_rounds = 2;
        start_match();
        play_round(3'b100, $urandom_range(0, 5));
        play_round(3'b010, $urandom_range(0, 5));
        start_match();
        check("restart_state", o_state, 3'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
